// File: rtl/line_pixel_streamer.sv
// Streams a filtered line out one pixel per valid/ready beat, with column/row
// coordinates, and holds one pending line so the next row can arrive early.
module line_pixel_streamer #(
  parameter int LINE_W   = 320,
  parameter int BORDER   = 2,
  parameter int MAX_ROWS = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_in,
  input  logic              line_start,
  output logic              line_ready,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic [8:0]        pix_col,
  output logic [7:0]        pix_row,
  output logic              pix_last,
  output logic              frame_done,
  output logic              overflow
);

  // state  | meaning
  // IDLE   | no line loaded, pix_valid low
  // STREAM | shift register holds a line, one beat offered per cycle
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam logic [8:0] COL_LAST = 9'(LINE_W - 1);
  localparam logic [8:0] COL_LO   = 9'(BORDER);
  localparam logic [8:0] COL_HI   = 9'(LINE_W - BORDER);
  localparam logic [7:0] ROW_LAST = 8'(MAX_ROWS - 1);

  logic [0:0]        state_q, state_d;
  logic [LINE_W-1:0] shreg_q, shreg_d;
  logic [LINE_W-1:0] pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [8:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;

  logic fire;
  logic last_fire;

  assign pix_valid  = (state_q == ST_STREAM);
  assign pix_col    = col_q;
  assign pix_row    = row_q;
  assign pix_last   = pix_valid && (col_q == COL_LAST);
  assign pix_data   = pix_valid && shreg_q[0] && (col_q >= COL_LO) && (col_q < COL_HI);
  assign line_ready = !pend_full_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

  assign fire      = pix_valid && pix_ready;
  assign last_fire = fire && (col_q == COL_LAST);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;

    if (state_q == ST_IDLE) begin
      if (line_start) begin
        shreg_d = line_in;
        col_d   = 9'd0;
        state_d = ST_STREAM;
      end
    end else begin
      if (fire) begin
        shreg_d = shreg_q >> 1;
        col_d   = col_q + 9'd1;
      end
      if (last_fire) begin
        col_d        = 9'd0;
        frame_done_d = (row_q == ROW_LAST);
        row_d        = (row_q == ROW_LAST) ? 8'd0 : row_q + 8'd1;
        // The pending slot drains this cycle, so a coincident line_start refills it.
        if (pend_full_q) begin
          shreg_d     = pend_q;
          pend_full_d = line_start;
          if (line_start) pend_d = line_in;
        end else if (line_start) begin
          shreg_d = line_in;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (line_start) begin
        if (!pend_full_q) begin
          pend_d      = line_in;
          pend_full_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      col_q        <= 9'd0;
      row_q        <= 8'd0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_line_pixel_streamer.sv
// Bench for line_pixel_streamer: table-driven single lines plus directed
// pending/overflow/frame/reset sequences, all beats checked against a scoreboard.
module tb_line_pixel_streamer;
  localparam int LW = 320;
  localparam int MR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [LW-1:0] line_in = '0;
  logic          line_start = 1'b0;
  logic          line_ready;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic          pix_data;
  logic [8:0]    pix_col;
  logic [7:0]    pix_row;
  logic          pix_last;
  logic          frame_done;
  logic          overflow;

  always #5 clk = ~clk;

  line_pixel_streamer #(.LINE_W(LW), .BORDER(2), .MAX_ROWS(MR)) dut (
    .clk(clk), .rst(rst), .line_in(line_in), .line_start(line_start),
    .line_ready(line_ready), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_col(pix_col), .pix_row(pix_row),
    .pix_last(pix_last), .frame_done(frame_done), .overflow(overflow)
  );

  typedef struct {
    logic [LW-1:0] pat;
    int            mode;
    int            exp_ones;
  } vec_t;

  vec_t        vecs[4];
  logic [18:0] exp_q[$];   // {data, col[8:0], row[7:0], last}
  int          checks = 0;
  int          errors = 0;
  int          model_row = 0;
  int          ones_seen = 0;
  int          fd_seen = 0;
  logic        fd_exp = 1'b0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output is the front of the queue on every valid cycle, stalled or not.
  always @(negedge clk) begin
    logic [18:0] e;
    if (frame_done || fd_exp) chk("frame_done", 32'(frame_done), 32'(fd_exp));
    if (frame_done) fd_seen++;
    fd_exp = 1'b0;
    if (!rst && pix_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(pix_valid), 32'd0);
      end else begin
        e = exp_q[0];
        chk("beat", 32'({pix_data, pix_col, pix_row, pix_last}), 32'(e));
        if (pix_ready) begin
          void'(exp_q.pop_front());
          ones_seen += 32'(pix_data);
          if (e[0] && e[8:1] == 8'(MR - 1)) fd_exp = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic push_line(input logic [LW-1:0] pat);
    for (int c = 0; c < LW; c++) begin
      logic d;
      d = (c < 2 || c >= LW - 2) ? 1'b0 : pat[c];
      exp_q.push_back({d, 9'(c), 8'(model_row), (c == LW - 1)});
    end
    model_row = (model_row + 1) % MR;
  endtask

  task automatic start_line(input logic [LW-1:0] pat, input bit accept);
    @(posedge clk) #1;
    line_in    = pat;
    line_start = 1'b1;
    if (accept) push_line(pat);
    @(posedge clk) #1;
    line_start = 1'b0;
  endtask

  task automatic wait_col(input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pix_valid && pix_col == 9'(c)) && n < 3000);
    if (n >= 3000) chk("timeout_col", 32'(pix_col), 32'(c));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || pix_valid) && n < 5000);
    chk("drain_done", 32'(exp_q.size() == 0 && !pix_valid), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk) #1;
    rst        = 1'b1;
    line_start = 1'b0;
    @(posedge clk);
    @(posedge clk) #1;
    rst = 1'b0;
    exp_q.delete();
    model_row = 0;
    fd_exp    = 1'b0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] la, lb, lc;
    int fd_base, vc;

    vecs[0] = '{pat: {10{32'hFFFFFFFF}}, mode: 0, exp_ones: 316};
    vecs[1] = '{pat: {10{32'hAAAAAAAA}}, mode: 1, exp_ones: 158};
    vecs[2] = '{pat: {10{32'h55555555}}, mode: 2, exp_ones: 158};
    vecs[3] = '{pat: {10{32'h00000000}}, mode: 0, exp_ones: 0};

    do_reset();
    @(negedge clk);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_data", 32'(pix_data), 0);
    chk("rst_col", 32'(pix_col), 0);
    chk("rst_row", 32'(pix_row), 0);
    chk("rst_last", 32'(pix_last), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_line_ready", 32'(line_ready), 1);

    // Single lines under different sink behaviours; rows 0..3 so the frame wraps.
    for (int i = 0; i < 4; i++) begin
      rdy_mode  = vecs[i].mode;
      ones_seen = 0;
      @(posedge clk) #1;
      line_in    = vecs[i].pat;
      line_start = 1'b1;
      push_line(vecs[i].pat);
      @(negedge clk);
      chk("valid_before_start", 32'(pix_valid), 0);
      @(posedge clk) #1;
      line_start = 1'b0;
      @(negedge clk);
      chk("valid_latency", 32'(pix_valid), 1);
      chk("first_col", 32'(pix_col), 0);
      wait_idle();
      chk("ones_count", 32'(ones_seen), 32'(vecs[i].exp_ones));
      chk("row_after", 32'(pix_row), 32'(model_row));
      chk("line_ready_idle", 32'(line_ready), 1);
    end
    rdy_mode = 0;
    @(negedge clk);
    chk("frame_done_count", 32'(fd_seen), 1);

    // Pending line follows with no bubble.
    do_reset();
    la = rand_line();
    lb = rand_line();
    start_line(la, 1);
    wait_col(100);
    start_line(lb, 1);
    @(negedge clk);
    chk("line_ready_pending", 32'(line_ready), 0);
    wait_col(319);
    @(negedge clk);
    chk("no_gap_valid", 32'(pix_valid), 1);
    chk("no_gap_col", 32'(pix_col), 0);
    chk("line_ready_freed", 32'(line_ready), 1);
    wait_idle();

    // Third line while pending is full is dropped.
    do_reset();
    la = rand_line();
    lb = rand_line();
    lc = ~lb;
    start_line(la, 1);
    wait_col(50);
    start_line(lb, 1);
    wait_col(60);
    chk("overflow_before_drop", 32'(overflow), 0);
    start_line(lc, 0);
    @(negedge clk);
    chk("overflow_set", 32'(overflow), 1);
    wait_idle();
    chk("rows_two_lines", 32'(pix_row), 2);
    chk("overflow_sticky", 32'(overflow), 1);

    // Four back-to-back lines, refilling pending on the draining beat.
    do_reset();
    fd_base = fd_seen;
    start_line(rand_line(), 1);
    wait_col(100);
    start_line(rand_line(), 1);
    wait_col(318);
    start_line(rand_line(), 1);
    wait_col(318);
    start_line(rand_line(), 1);
    wait_idle();
    @(negedge clk);
    chk("frame_done_single", 32'(fd_seen - fd_base), 1);
    chk("frame_row_wrap", 32'(pix_row), 0);
    chk("frame_no_overflow", 32'(overflow), 0);

    // Reset mid-stream with pending full and overflow set.
    do_reset();
    start_line(rand_line(), 1);
    wait_col(50);
    start_line(rand_line(), 1);
    wait_col(70);
    start_line(rand_line(), 0);
    wait_col(100);
    chk("pre_rst_overflow", 32'(overflow), 1);
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    exp_q.delete();
    model_row = 0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(pix_valid), 0);
    chk("mid_rst_row", 32'(pix_row), 0);
    chk("mid_rst_col", 32'(pix_col), 0);
    chk("mid_rst_line_ready", 32'(line_ready), 1);
    chk("mid_rst_overflow", 32'(overflow), 0);
    vc = 0;
    repeat (700) begin
      @(negedge clk);
      vc += 32'(pix_valid);
    end
    chk("no_beats_after_rst", 32'(vc), 0);
    chk("no_frame_done_after_rst", 32'(frame_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
